pulse_stretcher: RTL and testbench

PULSE_STRETCHER -- requirements
Module: pulse_stretcher

---
 rtl/pulse_stretcher.sv | 210 +++++++++++++++++++++
 tb/tb_pulse_stretcher.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_stretcher.sv
// -----------------------------------------------------------------------------
// pulse_stretcher
//
// Turns short event requests into human-visible pulses. Each channel, on a
// rising edge of its event input, holds its output high for hold_ticks
// prescaler ticks and then forces it low for gap_ticks ticks. One further
// event arriving while a channel is busy is remembered and replayed after the
// gap. Any event beyond that is discarded and reported on drop.
//
// Parameters
//   width          number of independent channels
//   tick_count_max prescaler terminal count (tick period = tick_count_max+1 clk)
//   hold_ticks     output-high duration in ticks (>= 1)
//   gap_ticks      forced output-low duration in ticks after each hold (>= 1)
//
// Ports
//   clk            sole clock, rising edge
//   rst_n          asynchronous active-low reset
//   event_in       synchronous, debounced event requests, one bit per channel
//   stretched_out  held pulse per channel (high while in HOLD)
//   busy           high while the channel is in HOLD or GAP
//   drop           one-cycle pulse when an event is discarded
// -----------------------------------------------------------------------------
module pulse_stretcher #(
   parameter int width          = 1,
   parameter int tick_count_max = 25000,
   parameter int hold_ticks     = 150,
   parameter int gap_ticks      = 50
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [width-1:0] event_in,
   output logic [width-1:0] stretched_out,
   output logic [width-1:0] busy,
   output logic [width-1:0] drop
);

   localparam int PRE_W     = (tick_count_max > 0) ? $clog2(tick_count_max + 1) : 1;
   localparam int MAX_TICKS = (hold_ticks > gap_ticks) ? hold_ticks : gap_ticks;
   localparam int CNT_W     = (MAX_TICKS > 0) ? $clog2(MAX_TICKS + 1) : 1;

   localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(tick_count_max);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(hold_ticks - 1);
   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(gap_ticks - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HOLD = 2'd1,
      ST_GAP  = 2'd2
   } state_t;

   // ---------------------------------------------------------------------------
   // Shared prescaler: tick is high for the single cycle the count sits at its
   // terminal value.
   // ---------------------------------------------------------------------------
   logic [PRE_W-1:0] pre_q;
   logic [PRE_W-1:0] pre_d;
   logic             tick;

   always_comb begin
      tick  = (pre_q == PRE_LAST);
      pre_d = tick ? '0 : (pre_q + PRE_W'(1));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre_q <= '0;
      end else begin
         pre_q <= pre_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Rising-edge detection. A level held high is seen only once. Because the
   // previous-value register resets to 0, an input already high at release
   // registers as an edge on the first clock.
   // ---------------------------------------------------------------------------
   logic [width-1:0] evt_prev_q;
   logic [width-1:0] evt_prev_d;
   logic [width-1:0] evt_edge;

   always_comb begin
      evt_prev_d = event_in;
      evt_edge   = event_in & ~evt_prev_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         evt_prev_q <= '0;
      end else begin
         evt_prev_q <= evt_prev_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Per-channel controller
   // ---------------------------------------------------------------------------
   for (genvar ch = 0; ch < width; ch++) begin : g_ch
      state_t           state_q;
      state_t           state_d;
      logic [CNT_W-1:0] cnt_q;
      logic [CNT_W-1:0] cnt_d;
      logic             pend_q;
      logic             pend_d;
      logic             stretch_q;
      logic             stretch_d;
      logic             busy_q;
      logic             busy_d;
      logic             drop_q;
      logic             drop_d;

      always_comb begin
         state_d = state_q;
         cnt_d   = cnt_q;
         pend_d  = pend_q;
         drop_d  = 1'b0;

         unique case (state_q)
            ST_IDLE: begin
               // A tick coinciding with acceptance is deliberately not counted,
               // so the hold always spans at least hold_ticks-1 full periods.
               if (evt_edge[ch]) begin
                  state_d = ST_HOLD;
                  cnt_d   = '0;
               end
            end

            ST_HOLD: begin
               if (tick) begin
                  if (cnt_q == HOLD_LAST) begin
                     state_d = ST_GAP;
                     cnt_d   = '0;
                  end else begin
                     cnt_d = cnt_q + CNT_W'(1);
                  end
               end
               if (evt_edge[ch]) begin
                  if (pend_q) begin
                     drop_d = 1'b1;
                  end else begin
                     pend_d = 1'b1;
                  end
               end
            end

            ST_GAP: begin
               if (tick && (cnt_q == GAP_LAST)) begin
                  // Exit cycle: an event arriving now is never dropped. With a
                  // pending request, the old one starts the new hold and the
                  // fresh edge becomes the new pending request.
                  cnt_d = '0;
                  if (pend_q) begin
                     state_d = ST_HOLD;
                     pend_d  = evt_edge[ch];
                  end else if (evt_edge[ch]) begin
                     state_d = ST_HOLD;
                  end else begin
                     state_d = ST_IDLE;
                  end
               end else begin
                  if (tick) begin
                     cnt_d = cnt_q + CNT_W'(1);
                  end
                  if (evt_edge[ch]) begin
                     if (pend_q) begin
                        drop_d = 1'b1;
                     end else begin
                        pend_d = 1'b1;
                     end
                  end
               end
            end

            default: begin
               state_d = ST_IDLE;
               cnt_d   = '0;
               pend_d  = 1'b0;
            end
         endcase

         // Outputs are registered copies of the next-state decode, so they
         // match the state register exactly without any path from event_in.
         stretch_d = (state_d == ST_HOLD);
         busy_d    = (state_d != ST_IDLE);
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            pend_q    <= 1'b0;
            stretch_q <= 1'b0;
            busy_q    <= 1'b0;
            drop_q    <= 1'b0;
         end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pend_q    <= pend_d;
            stretch_q <= stretch_d;
            busy_q    <= busy_d;
            drop_q    <= drop_d;
         end
      end

      assign stretched_out[ch] = stretch_q;
      assign busy[ch]          = busy_q;
      assign drop[ch]          = drop_q;
   end

endmodule

// File: tb/tb_pulse_stretcher.sv
// -----------------------------------------------------------------------------
// tb_pulse_stretcher
//
// Bench for pulse_stretcher with width=2, tick_count_max=3, hold_ticks=2,
// gap_ticks=1. Cycle n is the interval ending at the n-th rising edge after
// reset release (cycle 0 ends at the first edge). Inputs are driven and
// outputs are inspected on the falling edge preceding each rising edge.
// -----------------------------------------------------------------------------
module tb_pulse_stretcher;

   localparam int W = 2;
   localparam int T = 3;
   localparam int H = 2;
   localparam int G = 1;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [W-1:0] ev = '0;
   logic [W-1:0] so;
   logic [W-1:0] bs;
   logic [W-1:0] dr;

   int n_checks = 0;
   int n_fail   = 0;

   pulse_stretcher #(
      .width(W),
      .tick_count_max(T),
      .hold_ticks(H),
      .gap_ticks(G)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .event_in(ev),
      .stretched_out(so),
      .busy(bs),
      .drop(dr)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Reference model: each channel is just "ticks left until idle" plus a
   // count of queued requests. Output high while more than gap ticks remain.
   // ---------------------------------------------------------------------------
   int m_pc;
   int m_rem  [W];
   int m_pend [W];
   int m_prev [W];
   int m_drop [W];

   task automatic model_reset();
      m_pc = 0;
      for (int c = 0; c < W; c++) begin
         m_rem[c]  = 0;
         m_pend[c] = 0;
         m_prev[c] = 0;
         m_drop[c] = 0;
      end
   endtask

   task automatic model_step();
      bit tk;
      bit edg;
      bit exited;
      tk   = (m_pc == T);
      m_pc = tk ? 0 : m_pc + 1;
      for (int c = 0; c < W; c++) begin
         edg       = (ev[c] == 1'b1) && (m_prev[c] == 0);
         m_prev[c] = ev[c];
         m_drop[c] = 0;
         if (m_rem[c] == 0) begin
            if (edg) m_rem[c] = H + G;
         end else begin
            exited = 0;
            if (tk) begin
               m_rem[c] = m_rem[c] - 1;
               if (m_rem[c] == 0) begin
                  exited = 1;
                  if (m_pend[c] != 0) begin
                     m_rem[c]  = H + G;
                     m_pend[c] = edg ? 1 : 0;
                  end else if (edg) begin
                     m_rem[c] = H + G;
                  end
               end
            end
            if (!exited && edg) begin
               if (m_pend[c] != 0) m_drop[c] = 1;
               else m_pend[c] = 1;
            end
         end
      end
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) model_reset();
      else model_step();
   end

   function automatic logic [W-1:0] exp_s();
      logic [W-1:0] r;
      for (int c = 0; c < W; c++) r[c] = (m_rem[c] > G);
      return r;
   endfunction

   function automatic logic [W-1:0] exp_b();
      logic [W-1:0] r;
      for (int c = 0; c < W; c++) r[c] = (m_rem[c] > 0);
      return r;
   endfunction

   function automatic logic [W-1:0] exp_d();
      logic [W-1:0] r;
      for (int c = 0; c < W; c++) r[c] = (m_drop[c] != 0);
      return r;
   endfunction

   // ---------------------------------------------------------------------------
   // Stimulus helpers
   // ---------------------------------------------------------------------------
   // Leaves the bench on the falling edge just before cycle 0's rising edge.
   task automatic do_reset(input logic [W-1:0] ev_during);
      @(negedge clk);
      rst_n = 1'b0;
      ev    = ev_during;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic step(input logic [W-1:0] e);
      ev = e;
      @(posedge clk);
      @(negedge clk);
   endtask

   function automatic logic [W-1:0] b0(input bit c);
      return {1'b0, c};
   endfunction

   typedef struct {
      logic [W-1:0] ev;
      logic [W-1:0] s;
      logic [W-1:0] b;
      logic [W-1:0] d;
   } vec_t;

   vec_t tbl[16];
   int   rise_cnt;
   logic prev_s0;

   initial begin
      // Single-event table: edge at cycle 0, hold 1..7, gap 8..11, idle 12+.
      for (int n = 0; n < 16; n++) begin
         tbl[n].ev = (n <= 2) ? 2'b01 : 2'b00;
         tbl[n].s  = b0(n >= 1 && n <= 7);
         tbl[n].b  = b0(n >= 1 && n <= 11);
         tbl[n].d  = 2'b00;
      end

      // ---------------- single event, table driven ----------------
      do_reset(2'b00);
      for (int n = 0; n < 16; n++) begin
         chk($sformatf("single_s_c%0d", n), so, tbl[n].s);
         chk($sformatf("single_b_c%0d", n), bs, tbl[n].b);
         chk($sformatf("single_d_c%0d", n), dr, tbl[n].d);
         step(tbl[n].ev);
      end

      // ---------------- queued event (second edge at cycle 5) ----------------
      do_reset(2'b00);
      for (int n = 0; n < 26; n++) begin
         chk($sformatf("queue_s_c%0d", n), so, b0((n >= 1 && n <= 7) || (n >= 12 && n <= 19)));
         chk($sformatf("queue_b_c%0d", n), bs, b0(n >= 1 && n <= 23));
         chk($sformatf("queue_d_c%0d", n), dr, 2'b00);
         step((n == 0 || n == 5) ? 2'b01 : 2'b00);
      end

      // ---------------- overflow: edges at cycles 0, 2, 4 ----------------
      do_reset(2'b00);
      rise_cnt = 0;
      prev_s0  = 1'b0;
      for (int n = 0; n < 32; n++) begin
         chk($sformatf("ovf_d_c%0d", n), dr, b0(n == 5));
         chk($sformatf("ovf_s_c%0d", n), so, b0((n >= 1 && n <= 7) || (n >= 12 && n <= 19)));
         if (so[0] && !prev_s0) rise_cnt++;
         prev_s0 = so[0];
         step((n == 0 || n == 2 || n == 4) ? 2'b01 : 2'b00);
      end
      chk("ovf_hold_count", rise_cnt, 2);

      // ---------------- level held on channel 1 for 40 cycles ----------------
      do_reset(2'b00);
      rise_cnt = 0;
      prev_s0  = 1'b0;
      for (int n = 0; n < 46; n++) begin
         chk($sformatf("level_s_c%0d", n), so, {(n >= 1 && n <= 7), 1'b0});
         chk($sformatf("level_b_c%0d", n), bs, {(n >= 1 && n <= 11), 1'b0});
         chk($sformatf("level_d_c%0d", n), dr, 2'b00);
         if (so[1] && !prev_s0) rise_cnt++;
         prev_s0 = so[1];
         step((n < 40) ? 2'b10 : 2'b00);
      end
      chk("level_hold_count", rise_cnt, 1);

      // ---------------- reset mid-hold ----------------
      do_reset(2'b00);
      step(2'b01);
      repeat (3) step(2'b00);
      chk("rst_pre_s", so, 2'b01);
      rst_n = 1'b0;
      #1;
      chk("rst_async_s", so, 2'b00);
      chk("rst_async_b", bs, 2'b00);
      chk("rst_async_d", dr, 2'b00);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int n = 0; n < 20; n++) begin
         chk($sformatf("rst_idle_sb_c%0d", n), {so, bs}, 4'b0000);
         step(2'b00);
      end
      step(2'b01);
      chk("rst_new_edge_s", so, 2'b01);
      chk("rst_new_edge_b", bs, 2'b01);

      // ---------------- event high at reset release ----------------
      do_reset(2'b10);
      chk("rel_c0_s", so, 2'b00);
      step(2'b10);
      chk("rel_c1_s", so, 2'b10);
      chk("rel_c1_b", bs, 2'b10);

      // ---------------- edge exactly in the gap-exit cycle ----------------
      do_reset(2'b00);
      for (int n = 0; n < 20; n++) begin
         if (n >= 1) chk($sformatf("gapx_b_c%0d", n), bs, 2'b01);
         if (n >= 8 && n <= 11) chk($sformatf("gapx_s_c%0d", n), so, 2'b00);
         if (n >= 12) chk($sformatf("gapx_s_c%0d", n), so, 2'b01);
         chk($sformatf("gapx_d_c%0d", n), dr, 2'b00);
         step((n == 0 || n == 11) ? 2'b01 : 2'b00);
      end

      // ---------------- randomized against the model ----------------
      do_reset(2'b00);
      for (int n = 0; n < 3000; n++) begin
         chk("rnd_s", so, exp_s());
         chk("rnd_b", bs, exp_b());
         chk("rnd_d", dr, exp_d());
         if ($urandom_range(0, 399) == 0) begin
            rst_n = 1'b0;
            step(W'($urandom_range(0, 3)));
            rst_n = 1'b1;
         end else begin
            step({($urandom_range(0, 9) < 4), ($urandom_range(0, 9) < 3)});
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
